// File: rtl/cp_buf_ctrl.sv
// cp_buf_ctrl: packs 32-bit words into 128-bit entries of an external
// 128-deep circular buffer and streams whole entries back out.
module cp_buf_ctrl (
    input  logic         iClk,
    input  logic         iRsn,
    input  logic         iInVld,
    output logic         oInRdy,
    input  logic [31:0]  iInDt,
    output logic         oOutVld,
    input  logic         iOutRdy,
    output logic [127:0] oOutDt,
    output logic         oBufWrEn,
    output logic [3:0]   oBufWdSel,
    output logic [6:0]   oBufWrAddr,
    output logic [127:0] oBufWrDt,
    output logic         oBufRdEn,
    output logic [6:0]   oBufRdAddr,
    input  logic [127:0] iBufRdDt,
    input  logic         iClr,
    output logic [7:0]   oLevel,
    output logic         oEmpty,
    output logic         oFull
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_CAP,
        ST_VLD
    } rdState;

    localparam logic [7:0] DEPTH = 8'd128;

    logic [6:0] wp;
    logic [1:0] ln;
    logic [6:0] rp;
    logic [7:0] level;
    rdState     state;
    rdState     nxtState;
    logic       inAcc;
    logic       commit;
    logic       rdIssue;

    assign oLevel = level;
    assign oEmpty = (level == 8'd0);
    assign oFull  = (level == DEPTH);

    // Reset gating keeps the buffer untouched in a reset cycle.
    assign oInRdy = iRsn && !oFull && !iClr;
    assign inAcc  = iInVld && oInRdy;
    assign commit = inAcc && (ln == 2'd3);

    // Write port follows the input handshake combinationally.
    always_comb begin
        oBufWrEn   = 1'b0;
        oBufWdSel  = 4'd0;
        oBufWrAddr = 7'd0;
        oBufWrDt   = 128'd0;
        if (inAcc) begin
            oBufWrEn   = 1'b1;
            oBufWdSel  = 4'b0001 << ln;
            oBufWrAddr = wp;
            oBufWrDt   = {96'd0, iInDt} << {ln, 5'd0};
        end
    end

    // Read FSM next state; a read only issues on an input-idle cycle.
    always_comb begin
        nxtState = state;
        rdIssue  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (level != 8'd0 && !oOutVld) begin
                    nxtState = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!inAcc && iRsn && !iClr) begin
                    rdIssue  = 1'b1;
                    nxtState = ST_CAP;
                end
            end
            ST_CAP: begin
                nxtState = ST_VLD;
            end
            ST_VLD: begin
                if (iOutRdy) begin
                    nxtState = ST_IDLE;
                end
            end
            default: begin
                nxtState = ST_IDLE;
            end
        endcase
    end

    assign oBufRdEn   = rdIssue;
    assign oBufRdAddr = rdIssue ? rp : 7'd0;

    // FSM state register; flush and reset both return to idle.
    always_ff @(posedge iClk) begin
        if (!iRsn || iClr) begin
            state <= ST_IDLE;
        end else begin
            state <= nxtState;
        end
    end

    // Pointers and committed-entry level.
    always_ff @(posedge iClk) begin
        if (!iRsn || iClr) begin
            wp    <= 7'd0;
            ln    <= 2'd0;
            rp    <= 7'd0;
            level <= 8'd0;
        end else begin
            if (inAcc) begin
                ln <= ln + 2'd1;
            end
            if (commit) begin
                wp <= wp + 7'd1;
            end
            if (rdIssue) begin
                rp <= rp + 7'd1;
            end
            unique case ({commit, rdIssue})
                2'b10:   level <= level + 8'd1;
                2'b01:   level <= level - 8'd1;
                default: level <= level;
            endcase
        end
    end

    // Output block register; data is held while the consumer stalls.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            oOutVld <= 1'b0;
            oOutDt  <= 128'd0;
        end else if (iClr) begin
            oOutVld <= 1'b0;
        end else if (state == ST_CAP) begin
            oOutVld <= 1'b1;
            oOutDt  <= iBufRdDt;
        end else if (state == ST_VLD && iOutRdy) begin
            oOutVld <= 1'b0;
        end
    end

endmodule
